sr_flop_bank: RTL and testbench

//  Parametrised bank of WIDTH clocked SR flip-flops. Replaces per-bit gated SR latches.
//  The gated latches could oscillate when s=r=1 and then en fell; this bank removes that hazard:
//  - all state is edge-triggered;
//  - s=r=1 resolves deterministically according to a compile-time mode.

---
 rtl/sr_pkg.sv | 38 +++
 rtl/sr_cell.sv | 41 ++++
 rtl/sr_flop_bank.sv | 45 ++++
 tb/tb_sr_flop_bank.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - SR resolution modes and the shared next-state function.
package sr_pkg;

   typedef enum logic [1:0] {
      SR_SETDOM = 2'd0,
      SR_RSTDOM = 2'd1,
      SR_HOLD   = 2'd2,
      SR_TOGGLE = 2'd3
   } sr_mode_e;

   // Next value of one channel; s=r=1 is resolved by the compile-time mode.
   function automatic logic sr_next(input sr_mode_e mode,
                                    input logic     q,
                                    input logic     s,
                                    input logic     r,
                                    input logic     en);
      logic nxt;
      nxt = q;
      if (en) begin
         case ({s, r})
            2'b10:   nxt = 1'b1;
            2'b01:   nxt = 1'b0;
            2'b11: begin
               case (mode)
                  SR_SETDOM: nxt = 1'b1;
                  SR_RSTDOM: nxt = 1'b0;
                  SR_HOLD:   nxt = q;
                  SR_TOGGLE: nxt = ~q;
                  default:   nxt = q;
               endcase
            end
            default: nxt = q;
         endcase
      end
      return nxt;
   endfunction

endpackage

// File: rtl/sr_cell.sv
// rtl/sr_cell.sv - one clocked SR channel with edge pulses and sticky conflict flag.
module sr_cell
   import sr_pkg::*;
#(
   parameter sr_mode_e MODE      = SR_RSTDOM,
   parameter logic     RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic nrst,
   input  logic s,
   input  logic r,
   input  logic en,
   input  logic clr_conflict,
   output logic q,
   output logic rise,
   output logic fall,
   output logic conflict
);

   logic q_next;
   logic conflict_hit;

   assign q_next       = sr_next(MODE, q, s, r, en);
   assign conflict_hit = en & s & r;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         q        <= RESET_VAL;
         rise     <= 1'b0;
         fall     <= 1'b0;
         conflict <= 1'b0;
      end else begin
         q        <= q_next;
         rise     <= ~q & q_next;
         fall     <= q & ~q_next;
         // a new conflict outranks a clear in the same cycle
         conflict <= conflict_hit | (conflict & ~clr_conflict);
      end
   end

endmodule

// File: rtl/sr_flop_bank.sv
// rtl/sr_flop_bank.sv - WIDTH independent clocked SR channels with conflict summary.
module sr_flop_bank
   import sr_pkg::*;
#(
   parameter int                 WIDTH     = 8,
   parameter sr_mode_e           MODE      = SR_RSTDOM,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   input  logic [WIDTH-1:0] en,
   input  logic [WIDTH-1:0] clr_conflict,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] nq,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] conflict,
   output logic             any_conflict
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      sr_cell #(
         .MODE      (MODE),
         .RESET_VAL (RESET_VAL[i])
      ) u_cell (
         .clk          (clk),
         .nrst         (nrst),
         .s            (s[i]),
         .r            (r[i]),
         .en           (en[i]),
         .clr_conflict (clr_conflict[i]),
         .q            (q[i]),
         .rise         (rise[i]),
         .fall         (fall[i]),
         .conflict     (conflict[i])
      );
   end

   // nq is derived from the registered q, so it can never equal q
   assign nq           = ~q;
   assign any_conflict = |conflict;

endmodule

// File: tb/tb_sr_flop_bank.sv
// tb/tb_sr_flop_bank.sv - directed and random checks of sr_flop_bank in all four modes.
module tb_sr_flop_bank;
   import sr_pkg::*;

   localparam logic [7:0] RV = 8'hA5;
   localparam int SD = 0, RD = 1, HD = 2, TG = 3;

   logic       clk;
   logic       nrst;
   logic [7:0] s, r, en, clr;

   logic [7:0] q_o    [4];
   logic [7:0] nq_o   [4];
   logic [7:0] rise_o [4];
   logic [7:0] fall_o [4];
   logic [7:0] conf_o [4];
   logic       anyc_o [4];

   logic [7:0] mq    [4];
   logic [7:0] mrise [4];
   logic [7:0] mfall [4];
   logic [7:0] mconf [4];

   int checks   = 0;
   int failures = 0;

   for (genvar m = 0; m < 4; m++) begin : g_dut
      sr_flop_bank #(
         .WIDTH     (8),
         .MODE      (sr_mode_e'(m)),
         .RESET_VAL (RV)
      ) u_dut (
         .clk          (clk),
         .nrst         (nrst),
         .s            (s),
         .r            (r),
         .en           (en),
         .clr_conflict (clr),
         .q            (q_o[m]),
         .nq           (nq_o[m]),
         .rise         (rise_o[m]),
         .fall         (fall_o[m]),
         .conflict     (conf_o[m]),
         .any_conflict (anyc_o[m])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      logic [7:0] qn;
      for (int m = 0; m < 4; m++) begin
         if (!nrst) begin
            mq[m]    = RV;
            mrise[m] = 8'h00;
            mfall[m] = 8'h00;
            mconf[m] = 8'h00;
         end else begin
            for (int i = 0; i < 8; i++)
               qn[i] = sr_next(sr_mode_e'(m), mq[m][i], s[i], r[i], en[i]);
            mrise[m] = ~mq[m] & qn;
            mfall[m] = mq[m] & ~qn;
            mconf[m] = (en & s & r) | (mconf[m] & ~clr);
            mq[m]    = qn;
         end
      end
   endtask

   task automatic check_all();
      for (int m = 0; m < 4; m++) begin
         check($sformatf("m%0d_q", m),    q_o[m],    mq[m]);
         check($sformatf("m%0d_nq", m),   nq_o[m],   ~mq[m]);
         check($sformatf("m%0d_rise", m), rise_o[m], mrise[m]);
         check($sformatf("m%0d_fall", m), fall_o[m], mfall[m]);
         check($sformatf("m%0d_conf", m), conf_o[m], mconf[m]);
         check($sformatf("m%0d_any", m),  {7'b0, anyc_o[m]}, {7'b0, |mconf[m]});
         check($sformatf("m%0d_rf_excl", m), rise_o[m] & fall_o[m], 8'h00);
      end
   endtask

   task automatic step(input logic n, input logic [7:0] s_v, input logic [7:0] r_v,
                       input logic [7:0] en_v, input logic [7:0] clr_v);
      nrst = n;
      s    = s_v;
      r    = r_v;
      en   = en_v;
      clr  = clr_v;
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      nrst = 1'b0; s = '0; r = '0; en = '0; clr = '0;

      // reset held two cycles, then released with nothing enabled
      step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      step(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
      for (int m = 0; m < 4; m++) begin
         check("rst_q",    q_o[m],    8'hA5);
         check("rst_nq",   nq_o[m],   8'h5A);
         check("rst_rise", rise_o[m], 8'h00);
         check("rst_fall", fall_o[m], 8'h00);
         check("rst_conf", conf_o[m], 8'h00);
      end
      step(1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
      check("rel_q", q_o[RD], 8'hA5);

      // clear all, then set bit 0, redundant set, disabled reset
      step(1'b1, 8'h00, 8'hFF, 8'hFF, 8'h00);
      check("clr_q", q_o[SD], 8'h00);
      check("clr_fall", fall_o[SD], 8'hA5);
      step(1'b1, 8'h01, 8'h00, 8'hFF, 8'h00);
      check("set_q", q_o[RD], 8'h01);
      check("set_rise", rise_o[RD], 8'h01);
      step(1'b1, 8'h01, 8'h00, 8'hFF, 8'h00);
      check("reset_rise", rise_o[RD], 8'h00);
      check("reset_q", q_o[RD], 8'h01);
      step(1'b1, 8'h00, 8'hFF, 8'h00, 8'h00);
      check("dis_q", q_o[HD], 8'h01);
      check("dis_fall", fall_o[HD], 8'h00);

      // s=r=1 on bit 3 with q[3]=0
      step(1'b1, 8'h08, 8'h08, 8'h08, 8'h00);
      check("c1_setdom_q", q_o[SD], 8'h09);
      check("c1_rstdom_q", q_o[RD], 8'h01);
      check("c1_hold_q",   q_o[HD], 8'h01);
      check("c1_tog_q",    q_o[TG], 8'h09);
      check("c1_tog_rise", rise_o[TG], 8'h08);
      check("c1_conf",     conf_o[RD], 8'h08);
      check("c1_any",      {7'b0, anyc_o[HD]}, 8'h01);
      step(1'b1, 8'h08, 8'h08, 8'h08, 8'h00);
      check("c2_setdom_q",    q_o[SD], 8'h09);
      check("c2_setdom_rise", rise_o[SD], 8'h00);
      check("c2_tog_q",       q_o[TG], 8'h01);
      check("c2_tog_fall",    fall_o[TG], 8'h08);
      step(1'b1, 8'h08, 8'h08, 8'h08, 8'h00);
      check("c3_tog_q",    q_o[TG], 8'h09);
      check("c3_tog_rise", rise_o[TG], 8'h08);
      step(1'b1, 8'h00, 8'h00, 8'h00, 8'h08);
      check("c_clr_conf", conf_o[SD], 8'h00);
      check("c_clr_any",  {7'b0, anyc_o[SD]}, 8'h00);

      // sticky flag on bit 2, clear, then clear and set together
      step(1'b1, 8'h04, 8'h04, 8'h04, 8'h00);
      check("st_conf", conf_o[TG], 8'h04);
      check("st_any",  {7'b0, anyc_o[TG]}, 8'h01);
      check("st_setdom_q", q_o[SD], 8'h0D);
      step(1'b1, 8'h00, 8'h00, 8'h00, 8'h04);
      check("st_clr_conf", conf_o[TG], 8'h00);
      step(1'b1, 8'h04, 8'h04, 8'h04, 8'h00);
      step(1'b1, 8'h04, 8'h04, 8'h04, 8'h04);
      check("st_setwins_conf", conf_o[RD], 8'h04);
      check("st_setwins_any",  {7'b0, anyc_o[RD]}, 8'h01);

      // reset in the middle of a pending clear-all
      step(1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00);
      check("mid_pre_q", q_o[HD], 8'hFF);
      step(1'b0, 8'h00, 8'hFF, 8'hFF, 8'h00);
      check("mid_rst_q",    q_o[HD], 8'hA5);
      check("mid_rst_fall", fall_o[HD], 8'h00);
      check("mid_rst_rise", rise_o[HD], 8'h00);
      check("mid_rst_conf", conf_o[HD], 8'h00);
      step(1'b1, 8'h00, 8'hFF, 8'hFF, 8'h00);
      check("mid_post_q",    q_o[HD], 8'h00);
      check("mid_post_fall", fall_o[HD], 8'hA5);

      // random traffic against the reference model
      for (int c = 0; c < 10000; c++) begin
         step(($urandom_range(63) != 0),
              8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom & $urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
